// File: rtl/iterative_multiplier.sv
// Multi-cycle RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with a configurable
// radix, valid/ready handshakes on both sides and branch-tag based squashing.

package iterative_multiplier_pkg;
    localparam int BR_TAG_WIDTH = 4;

    typedef struct packed {
        logic                    sign;
        logic [BR_TAG_WIDTH-1:0] tag;
    } branch_tag_t;
endpackage

module iterative_multiplier
    import iterative_multiplier_pkg::*;
#(
    parameter int OPERAND_WIDTH  = 32,
    parameter int BITS_PER_CYCLE = 2,
    parameter int ROB_IDX_WIDTH  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [OPERAND_WIDTH-1:0] req_a,
    input  logic [OPERAND_WIDTH-1:0] req_b,
    input  logic [ROB_IDX_WIDTH-1:0] req_rob_idx,
    input  branch_tag_t              req_br_tag,
    input  logic                     flush,
    input  branch_tag_t              flush_tag,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [OPERAND_WIDTH-1:0] resp_data,
    output logic [ROB_IDX_WIDTH-1:0] resp_rob_idx,
    output branch_tag_t              resp_br_tag
);

    localparam int W     = OPERAND_WIDTH;
    localparam int B     = BITS_PER_CYCLE;
    localparam int PW    = 2 * OPERAND_WIDTH;
    localparam int ITERS = OPERAND_WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                   r_state;
    state_t                   w_nextState;

    logic [PW-1:0]            r_mcand;
    logic [W-1:0]             r_mplier;
    logic [PW-1:0]            r_acc;
    logic [CW-1:0]            r_cnt;
    logic                     r_neg;
    logic [1:0]               r_op;
    logic [ROB_IDX_WIDTH-1:0] r_robIdx;
    branch_tag_t              r_brTag;
    logic [W-1:0]             r_respData;

    logic                     w_accept;
    logic                     w_aNeg;
    logic                     w_bNeg;
    logic [W-1:0]             w_aMag;
    logic [W-1:0]             w_bMag;
    logic [PW-1:0]            w_partial;
    logic [PW-1:0]            w_product;
    logic                     w_lastStep;
    logic                     w_tagMatch;
    logic                     w_flushHit;

    // The extra BUSY step at r_cnt == ITERS applies the sign and registers the result.
    assign w_lastStep = (r_cnt == CW'(ITERS));

    // Only MULH/MULHSU treat rs1 as signed, only MULH treats rs2 as signed;
    // the magnitude of the most-negative value is correct when read as unsigned.
    assign w_aNeg = ((req_op == 2'b01) || (req_op == 2'b10)) && req_a[W-1];
    assign w_bNeg = (req_op == 2'b01) && req_b[W-1];
    assign w_aMag = w_aNeg ? -req_a : req_a;
    assign w_bMag = w_bNeg ? -req_b : req_b;

    assign w_partial = r_mcand * PW'(r_mplier[B-1:0]);
    assign w_product = r_neg ? -r_acc : r_acc;

    // Same-sign tags match when the flush tag is a subset of ours, otherwise the reverse.
    assign w_tagMatch = (r_brTag.sign == flush_tag.sign)
                      ? ((r_brTag.tag & flush_tag.tag) == flush_tag.tag)
                      : ((r_brTag.tag & flush_tag.tag) == r_brTag.tag);
    assign w_flushHit = flush && w_tagMatch && (r_state != IDLE);

    assign req_ready    = !flush && ((r_state == IDLE) || ((r_state == DONE) && resp_ready));
    assign w_accept     = req_valid && req_ready;
    assign resp_valid   = (r_state == DONE);
    assign resp_data    = r_respData;
    assign resp_rob_idx = r_robIdx;
    assign resp_br_tag  = r_brTag;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: a squash wins, and DONE can hand straight over to a new op.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                if (w_flushHit) begin
                    w_nextState = IDLE;
                end else if (w_lastStep) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (w_flushHit) begin
                    w_nextState = IDLE;
                end else if (resp_ready) begin
                    w_nextState = w_accept ? BUSY : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift-and-add while busy, then sign-fix into the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_op       <= '0;
            r_robIdx   <= '0;
            r_brTag    <= '0;
            r_respData <= '0;
        end else if (w_accept) begin
            r_mcand  <= {{W{1'b0}}, w_aMag};
            r_mplier <= w_bMag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= w_aNeg ^ w_bNeg;
            r_op     <= req_op;
            r_robIdx <= req_rob_idx;
            r_brTag  <= req_br_tag;
        end else if (r_state == BUSY) begin
            if (w_lastStep) begin
                r_respData <= (r_op == 2'b00) ? w_product[W-1:0] : w_product[PW-1:W];
            end else begin
                r_acc    <= r_acc + w_partial;
                r_mcand  <= r_mcand << B;
                r_mplier <= r_mplier >> B;
                r_cnt    <= r_cnt + 1'b1;
            end
        end
    end

endmodule
